line_window_cache: RTL and testbench
====================================

Name: line_window_cache

Overview:
- Line buffer between the GBA capture stage and imageGen.
- Stores captured 15-bit GBA pixels in a 4-slot ring of 240-pixel line buffers and expands them to RGB888.
- Serves the 3x3 neighbourhood around (curPxl, current line) that imageGen's smoothing and grid logic consume, with edge replication at the frame borders.
- Owns the line-advance handshake: imageGen sends nextLine and cacheUpdate; this block answers with sameLine.

Parameters:
- LINE_PIXELS, 240: pixels per GBA line.
- FRAME_LINES, 160: lines per GBA frame.
- NUM_SLOTS, 4: line buffers in the ring. Fixed at 4, so a mandatory assertion rejects any other value.

Ports:
- pxlClk  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- wrValid  in  1  one captured pixel is present on wrPxl this cycle.
- wrPxl  in  15  GBA BGR555: [14:10] blue, [9:5] green, [4:0] red.
- newFrameIn  in  1  level from the capture stage; its rising edge marks the start of a frame.
- curPxl  in  8  read column from imageGen, 0..LINE_PIXELS-1.
- nextLine  in  1  one-cycle request to advance to the next line.
- cacheUpdate  in  1  one-cycle end-of-active-line strobe.
- winRed, winGreen, winBlue  out  72 each  3x3 window per channel. Byte k = row*3+col. Row 0 = previous line, row 2 = next line; col 0 = curPxl-1, col 2 = curPxl+1.
- sameLine  out  1  the next line is not ready, so imageGen repeats the current line.
- overflow  out  1  sticky: a write was dropped because the ring was full.
- underrun  out  1  sticky: nextLine arrived while the next line was not ready.

Behaviour:
- Reset values: all window bytes 0, sameLine=1, overflow=0, underrun=0, every pointer and counter 0.
- Colour expansion: each 5-bit field c becomes {c, c[4:2]}. Examples: 5'h1F -> 8'hFF, 5'h10 -> 8'h84.
- Write side:
  - wrX counts 0..LINE_PIXELS-1 and stores the pixel into slot wrSlot at address wrX.
  - When wrX = LINE_PIXELS-1, wrX wraps to 0, wrSlot increments mod 4, and avail increments.
- avail (0..3) is the number of complete lines from slot C (the current read slot) onward.
- Full condition:
  - When avail = 3, writes are dropped and overflow is set. This protects slot C-1, which holds the previous line.
  - When avail = 3 and the write would complete a line, the write is dropped and avail does not change.
- Frame start, on the newFrameIn rising edge (tracked with a delay register):
  - wrX, wrSlot, C, rdY and avail all go to 0; overflow and underrun clear; sameLine goes to 1.
  - A wrValid in the same cycle is stored as pixel 0 of the new frame.
- Line advance:
  - nextLine with avail >= 2 and rdY < FRAME_LINES-1: C increments mod 4, rdY increments, avail decrements.
  - Otherwise the request is ignored. underrun is set if avail < 2.
  - Line completion and an accepted nextLine in the same cycle leave avail unchanged.
- sameLine:
  - Registered and updated only on the cacheUpdate cycle or at frame start, so it is stable during a line.
  - Value = (avail < 2) OR (rdY = FRAME_LINES-1), using post-update avail and rdY.
- Read side:
  - Column addresses: xl = max(curPxl-1, 0), xm = curPxl, xr = min(curPxl+1, LINE_PIXELS-1).
  - Rows: row0 reads slot C-1, or slot C when rdY = 0. row1 reads slot C. row2 reads slot C+1, or slot C when rdY = FRAME_LINES-1 or avail < 2.
  - When avail = 0, all window bytes are 0.
  - Latency is 1 cycle: the window registered at edge t+1 reflects curPxl sampled at edge t.
  - A curPxl value >= LINE_PIXELS is clamped to LINE_PIXELS-1.
- Storage: 4 x 240 x 15 bits. Each slot's storage has one write port and 3 asynchronous read ports (LUTRAM). Slot multiplexing happens before the output register.

Decomposition:
- In definePackage: GBA_LINE_PIXELS=240, GBA_FRAME_LINES=160, CACHE_SLOTS=4; typedef gbaPxl_t (15-bit); typedef rgb888_t (struct r, g, b of 8 bits); function expand5to8.
- Sub-module line_slot_ram: one 240x15 buffer with 1 write port and 3 asynchronous read ports, instantiated 4 times.

Test Plan:
- Reset release, then write 240 pixels of 15'h001F (red 31) and leave avail at 1 -> sameLine=1; at curPxl=0, winRed byte 4 = 8'hFF and bytes 0..8 all = 8'hFF (replicated edges); winGreen = winBlue = 0.
- Write line 0 as red = x mod 32 and line 1 as all 0, then pulse cacheUpdate -> sameLine=0. At curPxl=0, winRed bytes 3,4,5 = 00,00,08; byte 7 = 00. At curPxl=239, byte 5 = byte 4 = expand(239 mod 32 = 15) = 8'h7B.
- Write 3 lines while the reader holds, then send a 4th line -> overflow=1, avail stays 3, slot C-1 contents unchanged.
- nextLine when avail = 1 -> underrun=1; C, rdY and avail unchanged.
- Stream 160 lines while issuing nextLine whenever sameLine = 0 -> rdY reaches 159 and sameLine stays 1. At rdY=159, row 2 equals row 1; at rdY=0, row 0 equals row 1.
- newFrameIn rising edge mid-frame (rdY=80, avail=2) with a simultaneous wrValid -> all pointers 0, that pixel stored at slot 0 address 0, avail=0, window all 0, sameLine=1, sticky flags cleared.

Source files
------------

// File: rtl/line_window_cache_pkg.sv
// Shared types and helpers for the GBA line window cache.
// BGR555 pixel type, RGB888 bundle and the 5-to-8 bit colour expansion.
package line_window_cache_pkg;
    localparam int GBA_LINE_PIXELS = 240;
    localparam int GBA_FRAME_LINES = 160;
    localparam int CACHE_SLOTS     = 4;

    typedef logic [14:0] gbaPxl_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic rgb888_t gba_to_rgb(input gbaPxl_t p);
        rgb888_t o;
        o.r = expand5to8(p[4:0]);
        o.g = expand5to8(p[9:5]);
        o.b = expand5to8(p[14:10]);
        return o;
    endfunction
endpackage

// File: rtl/line_window_cache_if.sv
// Capture/imageGen side signals of the line window cache.
// master drives pixels and line control, slave returns window and status.
interface line_window_cache_if;
    import line_window_cache_pkg::*;

    logic        wrValid;
    gbaPxl_t     wrPxl;
    logic        newFrameIn;
    logic [7:0]  curPxl;
    logic        nextLine;
    logic        cacheUpdate;
    logic [71:0] winRed;
    logic [71:0] winGreen;
    logic [71:0] winBlue;
    logic        sameLine;
    logic        overflow;
    logic        underrun;

    modport master (
        output wrValid, wrPxl, newFrameIn, curPxl, nextLine, cacheUpdate,
        input  winRed, winGreen, winBlue, sameLine, overflow, underrun
    );

    modport slave (
        input  wrValid, wrPxl, newFrameIn, curPxl, nextLine, cacheUpdate,
        output winRed, winGreen, winBlue, sameLine, overflow, underrun
    );
endinterface

// File: rtl/line_window_cache_line_slot_ram.sv
// One GBA line buffer: a single write port and three asynchronous
// read ports so left/centre/right columns come out in the same cycle.
module line_slot_ram
    import line_window_cache_pkg::*;
#(
    parameter int DEPTH = GBA_LINE_PIXELS
) (
    input  logic            clk,
    input  logic            we,
    input  logic [7:0]      waddr,
    input  gbaPxl_t         wdata,
    input  logic [2:0][7:0] raddr,
    output gbaPxl_t [2:0]   rdata
);
    gbaPxl_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar i = 0; i < 3; i++) begin : g_rd
        assign rdata[i] = mem[raddr[i]];
    end
endmodule

// File: rtl/line_window_cache.sv
// Line window cache: 4-slot ring of GBA line buffers feeding imageGen
// with a registered 3x3 RGB888 neighbourhood and line-advance control.
module line_window_cache
    import line_window_cache_pkg::*;
#(
    parameter int LINE_PIXELS = GBA_LINE_PIXELS,
    parameter int FRAME_LINES = GBA_FRAME_LINES,
    parameter int NUM_SLOTS   = CACHE_SLOTS
) (
    input logic pxlClk,
    input logic rst,
    line_window_cache_if.slave bus
);
    if (NUM_SLOTS != 4) begin : g_bad_slots
        $error("line_window_cache: NUM_SLOTS must be 4");
    end

    localparam logic [7:0] X_LAST = 8'(LINE_PIXELS - 1);
    localparam logic [7:0] Y_LAST = 8'(FRAME_LINES - 1);

    logic        nf_d;
    logic [7:0]  wr_x, rd_y, wr_x_n, rd_y_n;
    logic [1:0]  wr_slot, cur, avail;
    logic [1:0]  wr_slot_n, cur_n, avail_n;
    logic        same_line, ovf, und;
    logic        same_n, ovf_n, und_n;
    logic        frame_start, full, line_done, adv;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_sel;
    logic [7:0]  cx;
    logic [2:0][7:0] raddr;
    logic [2:0][1:0] row_slot;
    gbaPxl_t [2:0]   rd_data [NUM_SLOTS];
    logic [71:0] win_r, win_g, win_b;
    logic [71:0] win_r_n, win_g_n, win_b_n;
    rgb888_t     pix;

    assign frame_start = bus.newFrameIn & ~nf_d;
    assign full        = (avail == 2'd3);
    assign line_done   = bus.wrValid & ~full & (wr_x == X_LAST);
    assign adv         = bus.nextLine & (avail >= 2'd2) & (rd_y < Y_LAST);

    // A pixel arriving with the frame edge becomes pixel 0 of the new frame.
    assign wr_en   = bus.wrValid & (frame_start | ~full);
    assign wr_addr = frame_start ? 8'd0 : wr_x;
    assign wr_sel  = frame_start ? 2'd0 : wr_slot;

    always_comb begin
        wr_x_n    = wr_x;
        wr_slot_n = wr_slot;
        cur_n     = cur;
        rd_y_n    = rd_y;
        avail_n   = avail;
        same_n    = same_line;
        ovf_n     = ovf;
        und_n     = und;
        if (frame_start) begin
            wr_x_n    = bus.wrValid ? 8'd1 : 8'd0;
            wr_slot_n = 2'd0;
            cur_n     = 2'd0;
            rd_y_n    = 8'd0;
            avail_n   = 2'd0;
            same_n    = 1'b1;
            ovf_n     = 1'b0;
            und_n     = 1'b0;
        end else begin
            if (bus.wrValid) begin
                if (full) begin
                    ovf_n = 1'b1;
                end else if (line_done) begin
                    wr_x_n    = 8'd0;
                    wr_slot_n = wr_slot + 2'd1;
                end else begin
                    wr_x_n = wr_x + 8'd1;
                end
            end
            if (adv) begin
                cur_n  = cur + 2'd1;
                rd_y_n = rd_y + 8'd1;
            end
            if (bus.nextLine && avail < 2'd2) und_n = 1'b1;
            avail_n = avail + 2'(line_done) - 2'(adv);
            if (bus.cacheUpdate) begin
                same_n = (avail_n < 2'd2) | (rd_y_n == Y_LAST);
            end
        end
    end

    assign cx = (bus.curPxl > X_LAST) ? X_LAST : bus.curPxl;
    assign raddr[0] = (cx == 8'd0) ? 8'd0 : cx - 8'd1;
    assign raddr[1] = cx;
    assign raddr[2] = (cx == X_LAST) ? X_LAST : cx + 8'd1;

    // Border rows replicate the current line.
    assign row_slot[0] = (rd_y == 8'd0) ? cur : cur - 2'd1;
    assign row_slot[1] = cur;
    assign row_slot[2] = (rd_y == Y_LAST || avail < 2'd2) ? cur : cur + 2'd1;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        line_slot_ram #(.DEPTH(LINE_PIXELS)) u_ram (
            .clk   (pxlClk),
            .we    (wr_en && (wr_sel == 2'(s))),
            .waddr (wr_addr),
            .wdata (bus.wrPxl),
            .raddr (raddr),
            .rdata (rd_data[s])
        );
    end

    always_comb begin
        win_r_n = '0;
        win_g_n = '0;
        win_b_n = '0;
        pix     = '0;
        if (avail != 2'd0 && !frame_start) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    pix = gba_to_rgb(rd_data[row_slot[r]][c]);
                    win_r_n[(r*3+c)*8 +: 8] = pix.r;
                    win_g_n[(r*3+c)*8 +: 8] = pix.g;
                    win_b_n[(r*3+c)*8 +: 8] = pix.b;
                end
            end
        end
    end

    always_ff @(posedge pxlClk or negedge rst) begin
        if (!rst) begin
            nf_d      <= 1'b0;
            wr_x      <= 8'd0;
            wr_slot   <= 2'd0;
            cur       <= 2'd0;
            rd_y      <= 8'd0;
            avail     <= 2'd0;
            same_line <= 1'b1;
            ovf       <= 1'b0;
            und       <= 1'b0;
            win_r     <= '0;
            win_g     <= '0;
            win_b     <= '0;
        end else begin
            nf_d      <= bus.newFrameIn;
            wr_x      <= wr_x_n;
            wr_slot   <= wr_slot_n;
            cur       <= cur_n;
            rd_y      <= rd_y_n;
            avail     <= avail_n;
            same_line <= same_n;
            ovf       <= ovf_n;
            und       <= und_n;
            win_r     <= win_r_n;
            win_g     <= win_g_n;
            win_b     <= win_b_n;
        end
    end

    assign bus.winRed   = win_r;
    assign bus.winGreen = win_g;
    assign bus.winBlue  = win_b;
    assign bus.sameLine = same_line;
    assign bus.overflow = ovf;
    assign bus.underrun = und;
endmodule

// File: tb/tb_line_window_cache.sv
// Scoreboard bench for line_window_cache: a line-numbered frame model
// predicts each registered window and status, a monitor compares them.
module tb_line_window_cache;
    logic pxlClk = 1'b0;
    logic rst;

    line_window_cache_if bus();

    line_window_cache dut (
        .pxlClk (pxlClk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 pxlClk = ~pxlClk;

    typedef struct {
        logic [71:0] r;
        logic [71:0] g;
        logic [71:0] b;
        logic        same;
        logic        ovf;
        logic        und;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_bad;

    // Model: frame lines kept by line number, not by ring slot.
    logic [14:0] mem [256][240];
    int   m_w;
    int   m_wx;
    int   m_rdy;
    bit   m_ovf, m_und, m_same, m_nfd;
    logic nf_lvl;

    function automatic logic [7:0] ex5(input logic [4:0] c);
        return 8'((c << 3) | (c >> 2));
    endfunction

    function automatic logic [7:0] rcp();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input bit wv, input logic [14:0] px,
                        input logic [7:0] cp, input bit nl, input bit cu);
        exp_t e;
        int av, cx;
        bit fs, done;
        int rows[3];
        int cols[3];
        logic [14:0] p;
        bus.wrValid     = wv;
        bus.wrPxl       = px;
        bus.newFrameIn  = nf_lvl;
        bus.curPxl      = cp;
        bus.nextLine    = nl;
        bus.cacheUpdate = cu;
        av = m_w - m_rdy;
        fs = nf_lvl && !m_nfd;
        e.r = '0;
        e.g = '0;
        e.b = '0;
        if (!fs && av > 0) begin
            cx = (cp > 239) ? 239 : int'(cp);
            cols[0] = (cx > 0) ? cx - 1 : 0;
            cols[1] = cx;
            cols[2] = (cx < 239) ? cx + 1 : 239;
            rows[0] = (m_rdy > 0) ? m_rdy - 1 : 0;
            rows[1] = m_rdy;
            rows[2] = (m_rdy < 159 && av >= 2) ? m_rdy + 1 : m_rdy;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    p = mem[rows[r]][cols[c]];
                    e.r[(r*3+c)*8 +: 8] = ex5(p[4:0]);
                    e.g[(r*3+c)*8 +: 8] = ex5(p[9:5]);
                    e.b[(r*3+c)*8 +: 8] = ex5(p[14:10]);
                end
            end
        end
        if (fs) begin
            m_w = 0; m_rdy = 0;
            m_ovf = 0; m_und = 0; m_same = 1;
            m_wx = wv ? 1 : 0;
            if (wv) mem[0][0] = px;
        end else begin
            done = 0;
            if (wv) begin
                if (av == 3) m_ovf = 1;
                else begin
                    mem[m_w][m_wx] = px;
                    if (m_wx == 239) begin m_wx = 0; done = 1; end
                    else m_wx++;
                end
            end
            if (nl && av < 2) m_und = 1;
            if (nl && av >= 2 && m_rdy < 159) m_rdy++;
            if (done) m_w++;
            if (cu) m_same = (m_w - m_rdy < 2) || (m_rdy == 159);
        end
        m_nfd = nf_lvl;
        e.same = m_same;
        e.ovf  = m_ovf;
        e.und  = m_und;
        q.push_back(e);
        @(negedge pxlClk);
    endtask

    exp_t mon_e;
    bit   mon_bad;

    always @(posedge pxlClk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_bad = 0;
            n_vec++;
            if (bus.winRed !== mon_e.r) begin
                mon_bad = 1;
                $display("FAIL win_red got %h want %h", bus.winRed, mon_e.r);
            end
            if (bus.winGreen !== mon_e.g) begin
                mon_bad = 1;
                $display("FAIL win_green got %h want %h", bus.winGreen, mon_e.g);
            end
            if (bus.winBlue !== mon_e.b) begin
                mon_bad = 1;
                $display("FAIL win_blue got %h want %h", bus.winBlue, mon_e.b);
            end
            if (bus.sameLine !== mon_e.same) begin
                mon_bad = 1;
                $display("FAIL same_line got %b want %b", bus.sameLine, mon_e.same);
            end
            if (bus.overflow !== mon_e.ovf) begin
                mon_bad = 1;
                $display("FAIL overflow got %b want %b", bus.overflow, mon_e.ovf);
            end
            if (bus.underrun !== mon_e.und) begin
                mon_bad = 1;
                $display("FAIL underrun got %b want %b", bus.underrun, mon_e.und);
            end
            if (mon_bad) n_bad++;
        end
    end

    int          cyc;
    bit          wv, nl, cu;
    logic [14:0] pix0;

    initial begin
        n_vec = 0; n_bad = 0;
        m_w = 0; m_wx = 0; m_rdy = 0;
        m_ovf = 0; m_und = 0; m_same = 1; m_nfd = 0;
        nf_lvl = 0;
        bus.wrValid = 0; bus.wrPxl = '0; bus.newFrameIn = 0;
        bus.curPxl = '0; bus.nextLine = 0; bus.cacheUpdate = 0;
        rst = 0;
        repeat (3) @(negedge pxlClk);
        chk("rst_red", bus.winRed, '0);
        chk("rst_green", bus.winGreen, '0);
        chk("rst_blue", bus.winBlue, '0);
        chk("rst_same", 72'(bus.sameLine), 72'd1);
        chk("rst_ovf", 72'(bus.overflow), 72'd0);
        chk("rst_und", 72'(bus.underrun), 72'd0);
        rst = 1;

        // One full red line, avail 1: all rows replicate it.
        for (int x = 0; x < 240; x++) step(1, 15'h001F, rcp(), 0, 0);
        step(0, '0, 8'd0, 0, 1);
        chk("p1_same", 72'(bus.sameLine), 72'd1);
        chk("p1_red", bus.winRed, {9{8'hFF}});
        chk("p1_green", bus.winGreen, '0);
        chk("p1_blue", bus.winBlue, '0);

        // New frame: ramp line then black line.
        nf_lvl = 1;
        step(0, '0, rcp(), 0, 0);
        nf_lvl = 0;
        for (int x = 0; x < 240; x++) step(1, 15'(x % 32), rcp(), 0, 0);
        for (int x = 0; x < 240; x++) step(1, 15'd0, rcp(), 0, 0);
        step(0, '0, 8'd0, 0, 1);
        chk("p2_same", 72'(bus.sameLine), 72'd0);
        chk("p2_row1_l", 72'(bus.winRed[47:24]), 72'h080000);
        chk("p2_row2_m", 72'(bus.winRed[63:56]), 72'h00);
        step(0, '0, 8'd239, 0, 0);
        chk("p2_right_edge", 72'(bus.winRed[47:32]), 72'h7B7B);

        // Advance once, then fill the ring and overrun it.
        step(0, '0, rcp(), 1, 1);
        for (int x = 0; x < 480; x++) step(1, 15'($urandom), rcp(), 0, 0);
        for (int x = 0; x < 240; x++) step(1, 15'($urandom), rcp(), 0, 0);
        chk("p3_ovf", 72'(bus.overflow), 72'd1);
        for (int i = 0; i < 20; i++) step(0, '0, rcp(), 0, 0);

        // Drain to avail 1, then request once more.
        step(0, '0, rcp(), 1, 0);
        step(0, '0, rcp(), 1, 0);
        step(0, '0, rcp(), 1, 0);
        chk("p4_und", 72'(bus.underrun), 72'd1);
        for (int i = 0; i < 10; i++) step(0, '0, rcp(), 0, i == 5);

        // Full-frame stream with a reader that follows sameLine.
        nf_lvl = 1;
        step(0, '0, rcp(), 0, 0);
        cyc = 0;
        while (m_rdy < 159 && cyc < 50000) begin
            wv = ($urandom_range(0, 15) != 0);
            cu = (cyc % 128 == 127);
            nl = cu && !bus.sameLine;
            step(wv, 15'($urandom), rcp(), nl, cu);
            cyc++;
        end
        n_vec++;
        if (m_rdy < 159) begin
            n_bad++;
            $display("FAIL stream_last_line got %0d want 159", m_rdy);
        end
        for (int i = 0; i < 600; i++) begin
            cu = (i % 128 == 127);
            step(1, 15'($urandom), rcp(), cu, cu);
        end
        chk("p5_same", 72'(bus.sameLine), 72'd1);

        // Second stream stopped mid-frame, then a new frame edge.
        nf_lvl = 0;
        step(0, '0, rcp(), 0, 0);
        nf_lvl = 1;
        step(0, '0, rcp(), 0, 0);
        nf_lvl = 0;
        cyc = 0;
        while (!(m_rdy == 80 && m_w - m_rdy == 2 && m_wx > 0)
               && cyc < 30000) begin
            wv = ($urandom_range(0, 15) != 0);
            cu = (cyc % 128 == 127);
            nl = (cu && !bus.sameLine && m_rdy < 80) || (cyc == 300);
            step(wv, 15'($urandom), rcp(), nl, cu);
            cyc++;
        end
        n_vec++;
        if (!(m_rdy == 80 && m_w - m_rdy == 2)) begin
            n_bad++;
            $display("FAIL midframe_reach got %0d want 80", m_rdy);
        end
        nf_lvl = 1;
        pix0 = 15'($urandom);
        step(1, pix0, rcp(), 0, 0);
        step(0, '0, rcp(), 0, 0);
        chk("p6_same", 72'(bus.sameLine), 72'd1);
        chk("p6_ovf", 72'(bus.overflow), 72'd0);
        chk("p6_und", 72'(bus.underrun), 72'd0);
        chk("p6_red", bus.winRed, '0);
        chk("p6_green", bus.winGreen, '0);
        for (int x = 1; x < 240; x++) step(1, 15'($urandom), rcp(), 0, 0);
        step(0, '0, 8'd0, 0, 0);
        chk("p6_pix0", 72'(bus.winRed[39:32]), 72'(ex5(pix0[4:0])));
        for (int i = 0; i < 8; i++) step(0, '0, rcp(), 0, 0);

        @(posedge pxlClk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
